// File: rtl/twi_init_sequencer_pkg.sv
// Shared types and constants for the TWI boot sequencer.
package twi_init_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_IDLE, S_SET_DIV, S_FETCH, S_DECODE, S_DELAY,
    S_WR_REG, S_POLL_S1, S_WR_DATA, S_POLL_S2, S_POLL_BUSY,
    S_CHECK, S_NEXT, S_DONE, S_ERROR
  } state_e;

  // ROM opcodes carried in the slave field
  localparam logic [7:0] OP_END   = 8'hFF;
  localparam logic [7:0] OP_DELAY = 8'hFE;

  // master status/control bit positions (big-endian numbering)
  localparam int B_START = 24;
  localparam int B_DACK  = 28;
  localparam int B_AACK  = 29;
  localparam int B_BUSY  = 31;

  localparam logic [0:1] CE_NONE = 2'b00;
  localparam logic [0:1] CE_CTRL = 2'b10;
  localparam logic [0:1] CE_DIV  = 2'b01;
  localparam logic [0:3] BE_CTRL = 4'b1011;
  localparam logic [0:3] BE_ALL  = 4'b1111;

  // control word: byte in [0:7], 7-bit address with R/W=0 in [16:23], start in [24]
  function automatic logic [0:31] ctrl_word(input logic [7:0] b, input logic [7:0] slave);
    return {b, 8'h00, slave[6:0], 1'b0, 1'b1, 7'b0};
  endfunction

  function automatic logic is_poll(input state_e s);
    return (s == S_WAIT_IDLE) || (s == S_POLL_S1) || (s == S_POLL_S2) || (s == S_POLL_BUSY);
  endfunction

endpackage

// File: rtl/twi_init_sequencer_if.sv
// Register port of the TWI master core (2-register PLB-style slave).
interface twi_init_sequencer_if;
  logic [0:31] wdata;
  logic [0:3]  be;
  logic [0:1]  wr_ce;
  logic [0:1]  rd_ce;
  logic [0:31] rdata;
  logic        wr_ack;
  logic        rd_ack;

  modport master (output wdata, be, wr_ce, rd_ce, input rdata, wr_ack, rd_ack);
  modport slave  (input wdata, be, wr_ce, rd_ce, output rdata, wr_ack, rd_ack);
endinterface

// File: rtl/twi_init_sequencer_timer.sv
// Loadable down-counter; shared by delay tick prescale and poll timeout.
module twi_init_sequencer_timer #(
  parameter int W = 32
)(
  input  logic         iPlbClk,
  input  logic         iPlbResetN,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt_q;

  // load wins over count; count stops at zero
  always_ff @(posedge iPlbClk) begin
    if (!iPlbResetN)            cnt_q <= '0;
    else if (load)              cnt_q <= value;
    else if (en && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign expired = (cnt_q == '0);
endmodule

// File: rtl/twi_init_sequencer.sv
// Boot sequencer: walks a ROM of (slave, reg, data) and issues 2-byte TWI
// writes through the master's register port, with retry/delay/timeout.
module twi_init_sequencer
  import twi_init_sequencer_pkg::*;
#(
  parameter int          ROM_AW     = 8,
  parameter logic [31:0] DIVIDER    = 32'd249,
  parameter int          MAX_RETRY  = 3,
  parameter int          DELAY_UNIT = 1000,
  parameter int          POLL_TMO   = 2**20
)(
  input  logic              iPlbClk,
  input  logic              iPlbResetN,
  input  logic              iStart,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError,
  output logic [ROM_AW-1:0] oErrIndex,
  output logic [ROM_AW-1:0] oRomAddr,
  input  logic [23:0]       iRomData,
  twi_init_sequencer_if.master twi
);
  state_e            state_q, state_d;
  logic [ROM_AW-1:0] idx_q, idx_d, eidx_q, eidx_d;
  logic [7:0]        retry_q, retry_d;
  logic [23:0]       ent_q, ent_d;
  logic [15:0]       ticks_q, ticks_d;
  logic              err_q, err_d;
  logic              gap_q, gap_d;   // forces CE low for one cycle after each ack

  logic [0:31] wdata;
  logic [0:3]  be;
  logic [0:1]  wr_ce, rd_ce;
  logic        tmr_en, tmr_reload, tmr_load, tmr_exp;
  logic [31:0] tmr_val;
  logic        wr_hit, rd_hit, poll_clear;
  state_e      poll_next;

  assign wr_hit = !gap_q && twi.wr_ack;
  assign rd_hit = !gap_q && twi.rd_ack;

  // timer reloads on entering a poll/delay state and on every delay tick
  assign tmr_load = tmr_reload ||
                    ((state_d != state_q) && (is_poll(state_d) || state_d == S_DELAY));
  assign tmr_val  = (state_d == S_DELAY) ? 32'(DELAY_UNIT - 1) : 32'(POLL_TMO - 1);

  twi_init_sequencer_timer #(.W(32)) u_tmr (
    .iPlbClk(iPlbClk), .iPlbResetN(iPlbResetN), .load(tmr_load),
    .value(tmr_val), .en(tmr_en), .expired(tmr_exp)
  );

  // state and datapath registers
  always_ff @(posedge iPlbClk) begin
    if (!iPlbResetN) begin
      state_q <= S_IDLE; idx_q <= '0; eidx_q <= '0; retry_q <= '0;
      ent_q <= '0; ticks_q <= '0; err_q <= 1'b0; gap_q <= 1'b0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; eidx_q <= eidx_d; retry_q <= retry_d;
      ent_q <= ent_d; ticks_q <= ticks_d; err_q <= err_d; gap_q <= gap_d;
    end
  end

  // exit condition of the current poll state
  always_comb begin
    poll_clear = 1'b0;
    poll_next  = S_CHECK;
    case (state_q)
      S_WAIT_IDLE: begin poll_clear = !twi.rdata[B_BUSY];  poll_next = S_SET_DIV;   end
      S_POLL_S1:   begin poll_clear = !twi.rdata[B_START]; poll_next = S_WR_DATA;   end
      S_POLL_S2:   begin poll_clear = !twi.rdata[B_START]; poll_next = S_POLL_BUSY; end
      default:     begin poll_clear = !twi.rdata[B_BUSY];  poll_next = S_CHECK;     end
    endcase
  end

  // next-state and bus outputs
  always_comb begin
    state_d = state_q; idx_d = idx_q; eidx_d = eidx_q; retry_d = retry_q;
    ent_d = ent_q; ticks_d = ticks_q; err_d = err_q; gap_d = 1'b0;
    wdata = '0; be = '0; wr_ce = CE_NONE; rd_ce = CE_NONE;
    tmr_en = 1'b0; tmr_reload = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR:
        if (iStart) begin
          state_d = S_WAIT_IDLE; idx_d = '0; eidx_d = '0; retry_d = '0;
        end
      // WAIT_IDLE shares the poll timeout so a dead master cannot hang boot
      S_WAIT_IDLE, S_POLL_S1, S_POLL_S2, S_POLL_BUSY: begin
        rd_ce  = gap_q ? CE_NONE : CE_CTRL;
        be     = BE_ALL;
        tmr_en = 1'b1;
        if (rd_hit) gap_d = 1'b1;
        if (rd_hit && state_q == S_POLL_BUSY) err_d = twi.rdata[B_DACK] | twi.rdata[B_AACK];
        if (rd_hit && poll_clear) state_d = poll_next;
        else if (tmr_exp) begin state_d = S_ERROR; eidx_d = idx_q; end
      end
      S_SET_DIV, S_WR_REG, S_WR_DATA: begin
        if (state_q == S_SET_DIV) begin
          wdata = DIVIDER; be = BE_ALL;
          wr_ce = gap_q ? CE_NONE : CE_DIV;
        end else begin
          wdata = ctrl_word((state_q == S_WR_REG) ? ent_q[15:8] : ent_q[7:0], ent_q[23:16]);
          be    = BE_CTRL;
          wr_ce = gap_q ? CE_NONE : CE_CTRL;
        end
        if (wr_hit) begin
          gap_d   = 1'b1;
          state_d = (state_q == S_SET_DIV) ? S_FETCH :
                    (state_q == S_WR_REG)  ? S_POLL_S1 : S_POLL_S2;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ent_d = iRomData;
        if (iRomData[23:16] == OP_END) state_d = S_DONE;
        else if (iRomData[23:16] == OP_DELAY) begin
          ticks_d = iRomData[15:0];
          state_d = (iRomData[15:0] == 16'd0) ? S_NEXT : S_DELAY;
        end else state_d = S_WR_REG;
      end
      S_DELAY: begin
        tmr_en = 1'b1;
        if (tmr_exp) begin
          if (ticks_q == 16'd1) state_d = S_NEXT;
          else begin ticks_d = ticks_q - 16'd1; tmr_reload = 1'b1; end
        end
      end
      S_CHECK:
        if (!err_q) state_d = S_NEXT;
        else if (int'(retry_q) < MAX_RETRY) begin retry_d = retry_q + 8'd1; state_d = S_WR_REG; end
        else begin state_d = S_ERROR; eidx_d = idx_q; end
      S_NEXT: begin
        retry_d = '0;
        idx_d   = idx_q + 1'b1;
        state_d = (&idx_q) ? S_DONE : S_FETCH;   // wrap past last entry ends the run
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign twi.wdata = wdata;
  assign twi.be    = be;
  assign twi.wr_ce = wr_ce;
  assign twi.rd_ce = rd_ce;

  assign oRomAddr  = idx_q;
  assign oErrIndex = eidx_q;
  assign oDone     = (state_q == S_DONE);
  assign oError    = (state_q == S_ERROR);
  assign oBusy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
endmodule

// File: tb/tb_twi_init_sequencer.sv
// Directed bench: sequencer + behavioural master register model + ROM.
module tb_twi_init_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err;
  logic [7:0]  err_idx, rom_addr;
  logic [23:0] rom_q;
  logic [23:0] rom [0:255];

  int n_err = 0;
  int n_chk = 0;

  twi_init_sequencer_if bus();

  twi_init_sequencer #(
    .ROM_AW(8), .DIVIDER(32'd249), .MAX_RETRY(3), .DELAY_UNIT(20), .POLL_TMO(200)
  ) dut (
    .iPlbClk(clk), .iPlbResetN(rst_n), .iStart(start), .oBusy(busy), .oDone(done),
    .oError(err), .oErrIndex(err_idx), .oRomAddr(rom_addr), .iRomData(rom_q), .twi(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  // ---------------- master register model ----------------
  logic        m_clr;
  int          m_nack_cfg;
  logic [6:0]  m_nack_slave;
  logic        m_force_busy, m_kill_rd;
  logic        m_wr_ack_q, m_rd_ack_q;
  logic [31:0] m_rdata_q, m_w, m_div_val;
  logic [3:0]  m_div_be, m_ctrl_be;
  logic        m_aack;
  int          m_div_wr, m_ctrl_wr, m_attempts, m_nack_left, m_start_cnt, m_busy_cnt, m_phase;
  logic [31:0] m_log [0:15];

  assign m_w = bus.wdata;

  always @(posedge clk) begin
    m_wr_ack_q <= 1'b0;
    m_rd_ack_q <= 1'b0;
    if (m_clr) begin
      m_div_wr <= 0; m_ctrl_wr <= 0; m_attempts <= 0; m_start_cnt <= 0; m_busy_cnt <= 0;
      m_phase <= 0; m_aack <= 1'b0; m_nack_left <= m_nack_cfg; m_div_val <= '0;
      m_div_be <= '0; m_ctrl_be <= '0; m_rdata_q <= '0;
    end else begin
      if (m_start_cnt != 0) m_start_cnt <= m_start_cnt - 1;
      if (m_phase == 2) begin
        if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
        else m_phase <= 0;
      end
      if (bus.wr_ce != 2'b00 && !m_wr_ack_q) begin
        m_wr_ack_q <= 1'b1;
        if (bus.wr_ce == 2'b01) begin
          m_div_wr <= m_div_wr + 1; m_div_val <= m_w; m_div_be <= bus.be;
        end else begin
          if (m_ctrl_wr < 16) m_log[m_ctrl_wr[3:0]] <= m_w;
          m_ctrl_wr <= m_ctrl_wr + 1; m_ctrl_be <= bus.be; m_start_cnt <= 3;
          if (m_phase == 0) begin
            m_phase <= 1;
            if (m_w[15:9] == m_nack_slave) begin
              m_attempts <= m_attempts + 1;
              m_aack <= (m_nack_left > 0);
              if (m_nack_left > 0) m_nack_left <= m_nack_left - 1;
            end else m_aack <= 1'b0;
          end else begin
            m_phase <= 2; m_busy_cnt <= 5;
          end
        end
      end
      if (bus.rd_ce != 2'b00 && !m_rd_ack_q && !m_kill_rd) begin
        m_rd_ack_q <= 1'b1;
        m_rdata_q  <= {24'h0, (m_start_cnt != 0), 3'b000, 1'b0, m_aack, 1'b0,
                       (m_phase != 0) || m_force_busy};
      end
    end
  end

  assign bus.wr_ack = m_wr_ack_q;
  assign bus.rd_ack = m_rd_ack_q;
  assign bus.rdata  = m_rdata_q;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic clr_model();
    m_clr = 1'b1; tick(1); m_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic rom_fill();
    for (int i = 0; i < 256; i++) rom[i] = 24'hFF0000;
  endtask

  task automatic wait_end(input int max, output int cyc);
    cyc = 0;
    while (!(done || err) && cyc < max) begin tick(1); cyc++; end
    chk("end_within_budget", 32'(cyc < max), 32'd1);
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; m_clr = 1'b1;
    m_nack_cfg = 0; m_nack_slave = 7'h22; m_force_busy = 1'b0; m_kill_rd = 1'b0;
    rom_fill();
    tick(3);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("rst_ce", {28'd0, bus.wr_ce, bus.rd_ce}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_erridx", {24'd0, err_idx}, 32'd0);
    rst_n = 1'b1; m_clr = 1'b0;
    tick(2);

    // single write entry then end
    rom[0] = 24'h4810AA; rom[1] = 24'hFF0000;
    clr_model(); pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_end(3000, cyc);
    chk("t1_done", {30'd0, done, err}, 32'd2);
    chk("t1_div_count", 32'(m_div_wr), 32'd1);
    chk("t1_div_val", m_div_val, 32'd249);
    chk("t1_div_be", {28'd0, m_div_be}, 32'hF);
    chk("t1_ctrl_count", 32'(m_ctrl_wr), 32'd2);
    chk("t1_reg_word", m_log[0], 32'h10009080);
    chk("t1_data_word", m_log[1], 32'hAA009080);
    chk("t1_ctrl_be", {28'd0, m_ctrl_be}, 32'hB);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // slave always NACKs address: 1 + MAX_RETRY attempts then error at entry 0
    rom_fill(); rom[0] = 24'h2205C3;
    m_nack_cfg = 100; clr_model(); pulse_start();
    wait_end(5000, cyc);
    chk("t2_flags", {30'd0, done, err}, 32'd1);
    chk("t2_attempts", 32'(m_attempts), 32'd4);
    chk("t2_erridx", {24'd0, err_idx}, 32'd0);

    // NACKing entry at index 1 reports index 1
    rom[0] = 24'h4810AA; rom[1] = 24'h2205C3; rom[2] = 24'hFF0000;
    clr_model(); pulse_start();
    wait_end(5000, cyc);
    chk("t2b_flags", {30'd0, done, err}, 32'd1);
    chk("t2b_erridx", {24'd0, err_idx}, 32'd1);
    chk("t2b_attempts", 32'(m_attempts), 32'd4);

    // NACK once, then ACK: one retry, success
    rom_fill(); rom[0] = 24'h2205C3;
    m_nack_cfg = 1; clr_model(); pulse_start();
    wait_end(5000, cyc);
    chk("t3_flags", {30'd0, done, err}, 32'd2);
    chk("t3_attempts", 32'(m_attempts), 32'd2);
    m_nack_cfg = 0;

    // delay opcode 5 ticks x 20 cycles; a start mid-run must be ignored
    rom_fill(); rom[0] = 24'hFE0005;
    clr_model(); pulse_start();
    cyc = 0;
    while (busy && cyc < 5000) begin start = (cyc == 30); tick(1); cyc++; end
    start = 1'b0;
    chk("t4_busy_min", 32'(cyc >= 100), 32'd1);
    chk("t4_busy_max", 32'(cyc <= 125), 32'd1);
    chk("t4_done", {30'd0, done, err}, 32'd2);
    chk("t4_div_count", 32'(m_div_wr), 32'd1);
    chk("t4_no_ctrl", 32'(m_ctrl_wr), 32'd0);

    // status reads never acked: timeout error after ~POLL_TMO cycles
    m_kill_rd = 1'b1; clr_model(); pulse_start();
    wait_end(1000, cyc);
    chk("t5_flags", {30'd0, done, err}, 32'd1);
    chk("t5_tmo_min", 32'(cyc >= 195), 32'd1);
    chk("t5_tmo_max", 32'(cyc <= 210), 32'd1);
    m_kill_rd = 1'b0;

    // reset while working on entry 1
    rom[0] = 24'h4810AA; rom[1] = 24'h4811BB; rom[2] = 24'hFF0000;
    clr_model(); pulse_start();
    cyc = 0;
    while (rom_addr != 8'd1 && cyc < 2000) begin tick(1); cyc++; end
    chk("t6_reach_entry1", 32'(cyc < 2000), 32'd1);
    rst_n = 1'b0; tick(1);
    chk("t6_rst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("t6_rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("t6_rst_ce", {28'd0, bus.wr_ce, bus.rd_ce}, 32'd0);
    rst_n = 1'b1; tick(1);

    // master reports busy: sequencer must hold in WAIT_IDLE
    clr_model(); m_force_busy = 1'b1; pulse_start();
    tick(40);
    chk("t7_hold_busy", {31'd0, busy}, 32'd1);
    chk("t7_no_div", 32'(m_div_wr), 32'd0);
    m_force_busy = 1'b0;
    wait_end(5000, cyc);
    chk("t7_done", {30'd0, done, err}, 32'd2);
    chk("t7_div_count", 32'(m_div_wr), 32'd1);
    chk("t7_ctrl_count", 32'(m_ctrl_wr), 32'd4);
    chk("t7_last_word", m_log[3], 32'hBB009080);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
